note_adsr: RTL and testbench

//   Per-voice note generator with ADSR amplitude envelope; successor to the fixed-decay note block.

---
 rtl/note_pkg.sv | 12 +
 rtl/note_env_scale.sv | 27 ++
 rtl/note_adsr.sv | 110 +++++++++++
 tb/tb_note_adsr.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/note_pkg.sv
// note_pkg: shared envelope state encoding and constants for the note voice
package note_pkg;
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } env_state_t;
    localparam int         MUL_SHIFT = 10;
    localparam logic [7:0] NOTE_OFF  = 8'd0;
endpackage

// File: rtl/note_env_scale.sv
// note_env_scale: registered symmetric sign-magnitude scaling of a signed sample by an envelope
module note_env_scale #(
    parameter int AM_WIDTH  = 8,
    parameter int ENV_WIDTH = 16
)(
    input  logic                        clk_theta,
    input  logic                        rst,
    input  logic                        en,
    input  logic signed [AM_WIDTH-1:0]  sample,
    input  logic        [ENV_WIDTH-1:0] env,
    output logic signed [AM_WIDTH-1:0]  am
);
    localparam logic [AM_WIDTH-1:0] MAX = {1'b0, {(AM_WIDTH-1){1'b1}}};
    localparam logic [AM_WIDTH-1:0] MIN = {1'b1, {(AM_WIDTH-1){1'b0}}};
    logic                          neg;
    logic [AM_WIDTH-1:0]           mag, p;
    logic [AM_WIDTH+ENV_WIDTH-1:0] prod;
    assign neg  = sample[AM_WIDTH-1];
    assign mag  = neg ? ((AM_WIDTH'(sample) == MIN) ? MAX : AM_WIDTH'(-sample)) : AM_WIDTH'(sample);
    assign prod = (AM_WIDTH+ENV_WIDTH)'(mag) * (AM_WIDTH+ENV_WIDTH)'(env);
    assign p    = AM_WIDTH'(prod >> ENV_WIDTH);
    // register the re-signed magnitude; silence when the voice is idle
    always_ff @(posedge clk_theta or posedge rst) begin
        if (rst) am <= '0;
        else     am <= !en ? '0 : (neg ? -p : p);
    end
endmodule

// File: rtl/note_adsr.sv
// note_adsr: per-voice theta generator with ADSR envelope (optional NOTE_ADSR_VELOCITY_EN adds velocity-scaled peak)
module note_adsr
    import note_pkg::*;
#(
    parameter int THETA_WIDTH   = 8,
    parameter int AM_WIDTH      = 8,
    parameter int ENV_WIDTH     = 16,
    parameter int ATTACK_STEP   = 4096,
    parameter int DECAY_MUL     = 1020,
    parameter int SUSTAIN_LEVEL = 32768,
    parameter int RELEASE_MUL   = 960,
    parameter int RELEASE_FLOOR = 64
)(
    input  logic                          clk_theta,
    input  logic                          rst,
    input  logic        [7:0]             noteid,
`ifdef NOTE_ADSR_VELOCITY_EN
    input  logic        [6:0]             velocity,
`endif
    input  logic signed [AM_WIDTH-1:0]    sample_in,
    output logic        [THETA_WIDTH-1:0] theta,
    output logic signed [AM_WIDTH-1:0]    am,
    output logic        [2:0]             env_state,
    output logic                          busy
);
    localparam logic [ENV_WIDTH-1:0] FULL = '1;
    env_state_t               state_q, state_d;
    logic [THETA_WIDTH-1:0]   theta_d;
    logic [ENV_WIDTH-1:0]     env_q, env_d, peak, dec_n, rel_n;
    logic [ENV_WIDTH:0]       att_sum;
    logic [ENV_WIDTH+10:0]    dec_p, rel_p;
    logic [7:0]               last_q;
    logic                     wrap, note_on, retrig, note_off;
    assign wrap     = theta == '1;
    assign note_on  = last_q == NOTE_OFF && noteid != NOTE_OFF;
    assign retrig   = last_q != NOTE_OFF && noteid != NOTE_OFF && noteid != last_q;
    assign note_off = last_q != NOTE_OFF && noteid == NOTE_OFF;
    assign att_sum  = {1'b0, env_q} + (ENV_WIDTH+1)'(ATTACK_STEP);
    assign dec_p    = (ENV_WIDTH+11)'(env_q) * (ENV_WIDTH+11)'(DECAY_MUL);
    assign rel_p    = (ENV_WIDTH+11)'(env_q) * (ENV_WIDTH+11)'(RELEASE_MUL);
    assign dec_n    = ENV_WIDTH'(dec_p >> MUL_SHIFT);
    assign rel_n    = ENV_WIDTH'(rel_p >> MUL_SHIFT);
    assign env_state = state_q;
    assign busy      = state_q != IDLE;
`ifdef NOTE_ADSR_VELOCITY_EN
    logic [ENV_WIDTH-1:0] peak_q;
    logic [6:0]           vel_eff;
    assign vel_eff = (velocity == 7'd0) ? 7'd1 : velocity;
    assign peak    = peak_q;
    // capture the attack target at each note start
    always_ff @(posedge clk_theta or posedge rst) begin
        if (rst)                    peak_q <= FULL;
        else if (note_on || retrig) peak_q <= {vel_eff, {(ENV_WIDTH-7){1'b1}}};
    end
`else
    assign peak = FULL;
`endif
    // next theta/envelope: note events take priority over the per-period envelope step
    always_comb begin
        state_d = state_q;
        env_d   = env_q;
        theta_d = (note_on && state_q == IDLE) ? '0 : theta + 1'b1;
        if (note_on || retrig) begin
            state_d = ATTACK;
        end else if (note_off) begin
            state_d = (state_q == IDLE) ? IDLE : RELEASE;
        end else if (wrap) begin
            case (state_q)
                ATTACK: begin
                    state_d = (att_sum >= {1'b0, peak}) ? DECAY : ATTACK;
                    env_d   = (att_sum >= {1'b0, peak}) ? peak : att_sum[ENV_WIDTH-1:0];
                end
                DECAY: begin
                    state_d = (dec_n <= ENV_WIDTH'(SUSTAIN_LEVEL)) ? SUSTAIN : DECAY;
                    env_d   = (dec_n <= ENV_WIDTH'(SUSTAIN_LEVEL)) ? ENV_WIDTH'(SUSTAIN_LEVEL) : dec_n;
                end
                RELEASE: begin
                    state_d = (rel_n < ENV_WIDTH'(RELEASE_FLOOR)) ? IDLE : RELEASE;
                    env_d   = (rel_n < ENV_WIDTH'(RELEASE_FLOOR)) ? '0 : rel_n;
                end
                default: ;
            endcase
        end
    end
    // voice state registers
    always_ff @(posedge clk_theta or posedge rst) begin
        if (rst) begin
            theta   <= '0;
            env_q   <= '0;
            state_q <= IDLE;
            last_q  <= NOTE_OFF;
        end else begin
            theta   <= theta_d;
            env_q   <= env_d;
            state_q <= state_d;
            last_q  <= noteid;
        end
    end
    note_env_scale #(
        .AM_WIDTH  (AM_WIDTH),
        .ENV_WIDTH (ENV_WIDTH)
    ) u_scale (
        .clk_theta (clk_theta),
        .rst       (rst),
        .en        (state_d != IDLE),
        .sample    (sample_in),
        .env       (env_d),
        .am        (am)
    );
endmodule

// File: tb/tb_note_adsr.sv
// tb_note_adsr: randomized stimulus against an arithmetic reference of the note voice envelope
module tb_note_adsr;
    localparam int TW   = 4;
    localparam int PER  = 1 << TW;
    localparam int PEAK = 65535;
    logic              clk_theta = 1'b0;
    logic              rst = 1'b0;
    logic [7:0]        noteid = 8'd0;
    logic signed [7:0] sample_in = 8'sd0;
    logic [TW-1:0]     theta;
    logic signed [7:0] am;
    logic [2:0]        env_state;
    logic              busy;
`ifdef NOTE_ADSR_VELOCITY_EN
    logic [6:0]        velocity = 7'd127;
`endif
    int checks = 0, failures = 0;
    int m_th, m_env, m_st, m_last, m_am;
    int cur;

    note_adsr #(.THETA_WIDTH(TW)) dut (
        .clk_theta (clk_theta),
        .rst       (rst),
        .noteid    (noteid),
`ifdef NOTE_ADSR_VELOCITY_EN
        .velocity  (velocity),
`endif
        .sample_in (sample_in),
        .theta     (theta),
        .am        (am),
        .env_state (env_state),
        .busy      (busy)
    );

    always #5 clk_theta = ~clk_theta;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic cmp_all();
        chk("theta", int'(theta), m_th);
        chk("state", int'(env_state), m_st);
        chk("busy", int'(busy), int'(m_st != 0));
        chk("am", int'(am), m_am);
    endtask

    function automatic int rnd_s();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        m_th = 0; m_env = 0; m_st = 0; m_last = 0; m_am = 0;
        #1 cmp_all();
        @(negedge clk_theta);
        rst = 1'b0;
    endtask

    // one clk_theta step: drive, apply the envelope rules to the model, compare after the edge
    task automatic step(input int n, input int s);
        bit on, rt, off, wr;
        int nn, mag, p;
        noteid = 8'(n);
        sample_in = 8'(s);
        @(posedge clk_theta);
        on  = (m_last == 0) && (n != 0);
        rt  = (m_last != 0) && (n != 0) && (n != m_last);
        off = (m_last != 0) && (n == 0);
        wr  = (m_th == PER - 1);
        m_th = (on && m_st == 0) ? 0 : (m_th + 1) % PER;
        if (on || rt) m_st = 1;
        else if (off) begin
            if (m_st != 0) m_st = 4;
        end else if (wr) begin
            if (m_st == 1) begin
                if (m_env + 4096 >= PEAK) begin m_env = PEAK; m_st = 2; end
                else m_env += 4096;
            end else if (m_st == 2) begin
                nn = (m_env * 1020) / 1024;
                if (nn <= 32768) begin m_env = 32768; m_st = 3; end
                else m_env = nn;
            end else if (m_st == 4) begin
                nn = (m_env * 960) / 1024;
                if (nn < 64) begin m_env = 0; m_st = 0; end
                else m_env = nn;
            end
        end
        m_last = n;
        mag  = (s == -128) ? 127 : (s < 0 ? -s : s);
        p    = (mag * m_env) / 65536;
        m_am = (m_st == 0) ? 0 : (s < 0 ? -p : p);
        #1 cmp_all();
        @(negedge clk_theta);
    endtask

    task automatic wait_st(input int target, input int bound, input string tag);
        for (int k = 0; k < bound && m_st != target; k++) step(cur, rnd_s());
        chk(tag, int'(env_state), target);
    endtask

    initial begin
        int th0;
        @(negedge clk_theta);
        do_reset();
        chk("rst_am", int'(am), 0);
        cur = 60;
        step(cur, rnd_s());
        chk("on_theta", int'(theta), 0);
        chk("on_state", int'(env_state), 1);
        wait_st(2, 2000, "to_decay");
        step(cur, 127);
        chk("am_pk_pos", int'(am), 126);
        step(cur, -128);
        chk("am_pk_neg", int'(am), -126);
        wait_st(3, 6000, "to_sustain");
        step(cur, 100);
        chk("am_sus_pos", int'(am), 50);
        step(cur, -100);
        chk("am_sus_neg", int'(am), -50);
        cur = 0;
        step(cur, rnd_s());
        chk("off_state", int'(env_state), 4);
        wait_st(0, 6000, "to_idle");
        step(cur, 90);
        chk("idle_am", int'(am), 0);
        chk("idle_busy", int'(busy), 0);
        cur = 60;
        step(cur, rnd_s());
        wait_st(2, 2000, "re_decay");
        for (int k = 0; k < 4000 && m_env > 50000; k++) step(cur, rnd_s());
        if (m_th == PER - 2) step(cur, rnd_s());
        th0 = m_th;
        cur = 64;
        step(cur, rnd_s());
        chk("retrig_theta", int'(theta), (th0 + 1) % PER);
        chk("retrig_state", int'(env_state), 1);
        for (int k = 0; k < PER && m_th != PER - 1; k++) step(cur, rnd_s());
        cur = 67;
        step(cur, 127);
        chk("wrap_evt_state", int'(env_state), 1);
        for (int k = 0; k < 3 * PER; k++) step(cur, rnd_s());
        do_reset();
        chk("mid_rst_theta", int'(theta), 0);
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                case ($urandom_range(0, 3))
                    0: cur = 0;
                    1: cur = 60;
                    2: cur = 64;
                    default: cur = int'($urandom_range(1, 255));
                endcase
            end
            if ($urandom_range(0, 1999) == 0) do_reset();
            else step(cur, rnd_s());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
